// File: rtl/crc32_frame_checker_if.sv
// crc32_frame_checker_if: byte-stream handshake and per-frame result bundle for the CRC-32 frame checker
interface crc32_frame_checker_if;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_last;
   logic        byte_ready;
   logic [31:0] crc_out;
   logic [31:0] crc_rx;
   logic        result;
   logic        done;
   modport master (output byte_data, byte_valid, byte_last,
                   input  byte_ready, crc_out, crc_rx, result, done);
   modport slave  (input  byte_data, byte_valid, byte_last,
                   output byte_ready, crc_out, crc_rx, result, done);
endinterface

// File: rtl/crc32_frame_checker.sv
// crc32_frame_checker: bit-serial IEEE 802.3 CRC-32 over the frame payload, checked against a 4-byte LSB-first trailer
module crc32_frame_checker (
   input logic                     clk,
   input logic                     rst_n,
   crc32_frame_checker_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] crc_q, crc_d, dl_q, dl_d, crc_out_q, crc_out_d, crc_rx_q, crc_rx_d;
   logic [7:0]  sh_q, sh_d;
   logic [2:0]  cnt_q, cnt_d, bit_q, bit_d;
   logic        last_q, last_d, res_q, res_d, en_q;
   logic        xfer, pop, fb, full;
   assign bus.byte_ready = en_q && (state_q == IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.crc_out    = crc_out_q;
   assign bus.crc_rx     = crc_rx_q;
   assign bus.result     = res_q;
   assign xfer = bus.byte_valid && bus.byte_ready;
   assign pop  = (cnt_q >= 3'd4);
   assign full = (cnt_q == 3'd5);
   assign fb   = crc_q[0] ^ sh_q[0];
   // Delay line: newest byte enters at [31:24], oldest sits in [7:0] and is the one popped
   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      dl_d      = dl_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      last_d    = last_q;
      crc_out_d = crc_out_q;
      crc_rx_d  = crc_rx_q;
      res_d     = res_q;
      case (state_q)
         IDLE: if (xfer) begin
            dl_d    = {bus.byte_data, dl_q[31:8]};
            cnt_d   = full ? 3'd5 : cnt_q + 3'd1;
            sh_d    = dl_q[7:0];
            last_d  = bus.byte_last;
            bit_d   = 3'd0;
            state_d = pop ? SHIFT : (bus.byte_last ? CHECK : IDLE);
         end
         SHIFT: begin
            crc_d   = {1'b0, crc_q[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
            sh_d    = {1'b0, sh_q[7:1]};
            bit_d   = bit_q + 3'd1;
            state_d = (bit_q == 3'd7) ? (last_q ? CHECK : IDLE) : SHIFT;
         end
         CHECK: begin
            crc_out_d = full ? ~crc_q : 32'h0;
            crc_rx_d  = full ? dl_q : 32'h0;
            res_d     = full && (~crc_q == dl_q);
            state_d   = DONE;
         end
         DONE: begin
            crc_d   = 32'hFFFF_FFFF;
            cnt_d   = 3'd0;
            dl_d    = 32'h0;
            last_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         crc_q     <= 32'hFFFF_FFFF;
         dl_q      <= 32'h0;
         sh_q      <= 8'h0;
         cnt_q     <= 3'd0;
         bit_q     <= 3'd0;
         last_q    <= 1'b0;
         crc_out_q <= 32'h0;
         crc_rx_q  <= 32'h0;
         res_q     <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         dl_q      <= dl_d;
         sh_q      <= sh_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         last_q    <= last_d;
         crc_out_q <= crc_out_d;
         crc_rx_q  <= crc_rx_d;
         res_q     <= res_d;
         en_q      <= 1'b1;
      end
   end
endmodule
